// File: rtl/telem_pkg.sv
// Shared constants and types for the telemetry frame arbiter: sync byte,
// FSM state codes and the frame phase enum.
package telem_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_GRANT    = 2'd1;
   localparam logic [1:0] ST_TX_START = 2'd2;
   localparam logic [1:0] ST_TX_WAIT  = 2'd3;

   typedef enum logic [1:0] {
      PH_SYNC = 2'd0,
      PH_TAG  = 2'd1,
      PH_PAY  = 2'd2,
      PH_CSUM = 2'd3
   } phase_t;

   // Index width that stays legal for a single source.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr,
// searching circularly.
module rr_arbiter import telem_pkg::*; #(
   parameter int N  = 3,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_valid
);

   always_comb begin
      int j;
      j         = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      // Walk from farthest to nearest so the closest requester wins last.
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/telemetry_frame_arbiter.sv
// Round-robin shares one uart_tx between N_SRC FWFT telemetry FIFOs, sending
// each popped word as SYNC, TAG, payload (MSB first), XOR checksum.
module telemetry_frame_arbiter import telem_pkg::*; #(
   parameter int         N_SRC        = 3,
   parameter int         DWIDTH       = 96,
   parameter int         LEN [N_SRC]  = '{12, 12, 8},
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
   localparam int        IW           = idx_w(N_SRC)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [N_SRC-1:0]          src_empty,
   input  logic [N_SRC*DWIDTH-1:0]   src_rd_data,
   output logic [N_SRC-1:0]          src_rd_en,
   output logic                      uart_start,
   output logic [7:0]                uart_din,
   input  logic                      uart_done,
   output logic                      busy,
   output logic [IW-1:0]             grant_idx,
   output logic [15:0]               frame_cnt
);

   logic [1:0]        state;
   phase_t            phase;
   logic [IW-1:0]     rr_ptr;
   logic [IW-1:0]     arb_idx;
   logic              arb_valid;
   logic [DWIDTH-1:0] shreg;
   logic [DWIDTH-1:0] lane_sel;
   logic [7:0]        cur_len;
   logic [7:0]        byte_ctr;
   logic [7:0]        csum;
   logic [7:0]        tag;
   logic [7:0]        cur_byte;

   rr_arbiter #(.N(N_SRC), .IW(IW)) u_arb (
      .req       (~src_empty),
      .ptr       (rr_ptr),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   always_comb begin
      lane_sel = '0;
      cur_len  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_idx == IW'(i)) begin
            lane_sel = src_rd_data[i*DWIDTH +: DWIDTH];
            cur_len  = 8'(LEN[i]);
         end
      end
   end

   assign tag = 8'(grant_idx);

   always_comb begin
      case (phase)
         PH_SYNC: cur_byte = SYNC_BYTE;
         PH_TAG:  cur_byte = tag;
         PH_PAY:  cur_byte = shreg[DWIDTH-1 -: 8];
         default: cur_byte = csum;
      endcase
   end

   assign busy       = (state != ST_IDLE);
   assign uart_start = (state == ST_TX_START);
   assign uart_din   = (state == ST_TX_START || state == ST_TX_WAIT) ? cur_byte : 8'h00;

   always_comb begin
      src_rd_en = '0;
      if (state == ST_GRANT)
         src_rd_en[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         phase     <= PH_SYNC;
         grant_idx <= '0;
         rr_ptr    <= '0;
         shreg     <= '0;
         byte_ctr  <= '0;
         csum      <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en && arb_valid) begin
                  grant_idx <= arb_idx;
                  state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // Left-justify the payload so the first byte sits at the top.
               shreg    <= lane_sel << (DWIDTH - 8 * int'(cur_len));
               csum     <= tag;
               phase    <= PH_SYNC;
               byte_ctr <= '0;
               state    <= ST_TX_START;
            end
            ST_TX_START: state <= ST_TX_WAIT;
            default: begin
               if (uart_done) begin
                  state <= ST_TX_START;
                  case (phase)
                     PH_SYNC: phase <= PH_TAG;
                     PH_TAG:  phase <= PH_PAY;
                     PH_PAY: begin
                        csum  <= csum ^ cur_byte;
                        shreg <= shreg << 8;
                        if (byte_ctr == cur_len - 8'd1)
                           phase <= PH_CSUM;
                        else
                           byte_ctr <= byte_ctr + 8'd1;
                     end
                     default: begin
                        frame_cnt <= frame_cnt + 16'd1;
                        rr_ptr    <= (grant_idx == IW'(N_SRC - 1)) ? '0 : grant_idx + IW'(1);
                        state     <= ST_IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_telemetry_frame_arbiter.sv
// Randomized bench for telemetry_frame_arbiter: FWFT FIFO and uart_tx models,
// with a byte-stream reference built from the frame rules.
module tb_telemetry_frame_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [2:0]   src_empty;
   logic [287:0] src_rd_data;
   logic [2:0]   src_rd_en;
   logic         uart_start;
   logic [7:0]   uart_din;
   logic         uart_done;
   logic         busy;
   logic [1:0]   grant_idx;
   logic [15:0]  frame_cnt;

   telemetry_frame_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .src_empty   (src_empty),
      .src_rd_data (src_rd_data),
      .src_rd_en   (src_rd_en),
      .uart_start  (uart_start),
      .uart_din    (uart_din),
      .uart_done   (uart_done),
      .busy        (busy),
      .grant_idx   (grant_idx),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   int          len_tab [3] = '{12, 12, 8};
   logic [95:0] fq [3][$];
   logic [7:0]  exp_q [$];
   logic [7:0]  log_q [$];
   int          gnt_log [$];
   int          passed = 0, total = 0;
   int          m_ptr = 0, m_frames = 0, pop_pend = -1;
   int          u_cnt = 0, fbyte = 0, flen = 0, start_cnt = 0, rd_cnt = 0;
   logic [7:0]  held_din;
   logic        din_moved, spurious = 1'b0, prev_en;
   logic [2:0]  prev_mask;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic void drive_fifo();
      for (int i = 0; i < 3; i++) begin
         src_empty[i] = (fq[i].size() == 0);
         src_rd_data[i*96 +: 96] = (fq[i].size() > 0) ? fq[i][0] : 96'h0;
      end
   endfunction

   function automatic bit all_empty();
      return fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0;
   endfunction

   // Expected frame for word w from source s.
   function automatic void build_frame(input int s, input logic [95:0] w);
      logic [7:0] cs, b;
      cs = 8'(s);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(s));
      for (int k = 0; k < len_tab[s]; k++) begin
         b = w[(len_tab[s] - 1 - k) * 8 +: 8];
         exp_q.push_back(b);
         cs ^= b;
      end
      exp_q.push_back(cs);
   endfunction

   task automatic step();
      int e;
      prev_mask = ~src_empty;
      prev_en   = en;
      @(negedge clk);
      uart_done = 1'b0;
      if (pop_pend >= 0) begin
         void'(fq[pop_pend].pop_front());
         pop_pend = -1;
         drive_fifo();
      end
      if (src_rd_en != 3'b000) begin
         e = -1;
         for (int k = 2; k >= 0; k--)
            if (prev_mask[(m_ptr + k) % 3]) e = (m_ptr + k) % 3;
         chk("grant_with_en", prev_en, 1'b1);
         chk("grant_src", src_rd_en, (e < 0) ? 3'b000 : 3'(1 << e));
         rd_cnt++;
         if (e >= 0) begin
            build_frame(e, fq[e][0]);
            gnt_log.push_back(e);
            m_ptr    = (e + 1) % 3;
            pop_pend = e;
            flen     = len_tab[e] + 3;
         end
         fbyte = 0;
      end
      if (u_cnt > 0) begin
         if (uart_din !== held_din) din_moved = 1'b1;
         u_cnt--;
         if (u_cnt == 0) begin
            uart_done = 1'b1;
            chk("din_hold", din_moved, 1'b0);
            if (fbyte == flen) m_frames++;
         end
      end
      if (uart_start) begin
         if (exp_q.size() == 0) chk("unexpected_start", 1'b1, 1'b0);
         else chk("byte", uart_din, exp_q.pop_front());
         log_q.push_back(uart_din);
         held_din  = uart_din;
         din_moved = 1'b0;
         u_cnt     = 20;
         fbyte++;
         start_cnt++;
         if (spurious && $urandom_range(1) == 1) uart_done = 1'b1;
      end else if (spurious && !busy && u_cnt == 0 && $urandom_range(3) == 0) begin
         uart_done = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(all_empty() && exp_q.size() == 0 && u_cnt == 0 && pop_pend < 0 && !busy)
             && n < budget) begin
         step();
         n++;
      end
      chk("idle_reached", n < budget, 1'b1);
      chk("frame_cnt", frame_cnt, 16'(m_frames));
   endtask

   task automatic wait_frame_done(input int budget);
      int n = 0;
      while (!(exp_q.size() == 0 && u_cnt == 0 && pop_pend < 0 && !busy) && n < budget) begin
         step();
         n++;
      end
      chk("frame_done", n < budget, 1'b1);
   endtask

   logic [7:0] t1_bytes [11] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11,
                                  8'h00, 8'h00, 8'h00, 8'h1E, 8'h0D};

   initial begin
      int base, n, s0, s;
      reset = 1'b1; en = 1'b1; uart_done = 1'b0;
      drive_fifo();
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_start", uart_start, 1'b0);
      chk("rst_rd_en", src_rd_en, 3'b000);
      chk("rst_din", uart_din, 8'h00);
      chk("rst_grant", grant_idx, 2'd0);
      chk("rst_frame_cnt", frame_cnt, 16'd0);
      reset = 1'b0;
      step();

      // Single frame from source 2 only.
      base = log_q.size();
      fq[2].push_back({32'hDEADBEEF, 64'h00000011_0000001E});
      drive_fifo();
      s0 = start_cnt; n = 0;
      while (start_cnt == s0 && n < 10) begin step(); n++; end
      chk("first_start_latency", n, 2);
      wait_idle(2000);
      for (int k = 0; k < 11; k++) chk("t1_byte", log_q[base + k], t1_bytes[k]);
      chk("t1_rd_cnt", rd_cnt, 1);

      // Two words in every FIFO: strict rotation.
      base = gnt_log.size(); s0 = rd_cnt;
      for (int i = 0; i < 3; i++)
         repeat (2) fq[i].push_back({$urandom(), $urandom(), $urandom()});
      drive_fifo();
      wait_idle(8000);
      chk("t2_rd_cnt", rd_cnt - s0, 6);
      for (int k = 0; k < 6; k++) chk("t2_order", gnt_log[base + k], k % 3);

      // en dropped during src0 payload byte 3.
      fq[0].push_back({$urandom(), $urandom(), $urandom()});
      fq[1].push_back({$urandom(), $urandom(), $urandom()});
      drive_fifo();
      n = 0;
      while (!(fbyte == 6 && gnt_log.size() > 0 && gnt_log[gnt_log.size() - 1] == 0) && n < 2000) begin
         step(); n++;
      end
      chk("t3_reach_pay3", n < 2000, 1'b1);
      en = 1'b0;
      wait_frame_done(2000);
      s0 = start_cnt;
      repeat (100) step();
      chk("t3_no_start_en_low", start_cnt - s0, 0);
      chk("t3_busy_en_low", busy, 1'b0);
      en = 1'b1;
      wait_idle(2000);
      chk("t3_resume_src1", gnt_log[gnt_log.size() - 1], 1);

      // Reset in TX_WAIT of payload byte 5 (pointer is at source 2 here).
      fq[0].push_back({$urandom(), $urandom(), $urandom()});
      fq[2].push_back({$urandom(), $urandom(), $urandom()});
      drive_fifo();
      n = 0;
      while (fbyte != 8 && n < 2000) begin step(); n++; end
      chk("t4_reach_pay5", n < 2000, 1'b1);
      chk("t4_src2_first", gnt_log[gnt_log.size() - 1], 2);
      repeat (5) step();
      reset = 1'b1;
      #1;
      chk("t4_start", uart_start, 1'b0);
      chk("t4_rd_en", src_rd_en, 3'b000);
      chk("t4_busy", busy, 1'b0);
      chk("t4_frame_cnt", frame_cnt, 16'd0);
      exp_q.delete(); u_cnt = 0; uart_done = 1'b0; m_ptr = 0; m_frames = 0; fbyte = 0;
      repeat (2) step();
      reset = 1'b0;
      base = log_q.size();
      wait_idle(2000);
      chk("t4_sync", log_q[base], 8'hA5);
      chk("t4_tag", log_q[base + 1], 8'h00);

      // Random traffic, en toggling and spurious uart_done outside TX_WAIT.
      spurious = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         step();
         if ($urandom_range(29) == 0) begin
            s = $urandom_range(2);
            if (fq[s].size() < 3) begin
               fq[s].push_back({$urandom(), $urandom(), $urandom()});
               drive_fifo();
            end
         end
         if ($urandom_range(149) == 0) en = ~en;
      end
      en = 1'b1;
      wait_idle(30000);
      spurious = 1'b0;
      chk("final_exp_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
